// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the fetch-stage gshare branch predictor.
// Contents:
//   XLEN             datapath / PC width
//   instr_t          fetched instruction fields (RV32 base layout)
//   bp_cnt_t         2-bit saturating pattern-table counter
//   btb_entry_t      branch target buffer entry {valid, tag, target}
//   bpCntUpdate      saturating counter step toward the resolved outcome
package branch_predictor_pkg;

    localparam int XLEN        = 32;
    localparam int BP_IDX_BITS = 6;
    // Global history length; must be at least 2 and no larger than BP_IDX_BITS.
    localparam int BP_GHR_BITS = 6;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } bp_cnt_t;

    // The tag field is full width so the entry layout does not depend on the
    // index width; unused upper tag bits are simply zero.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
    } btb_entry_t;

    // Move one step toward the outcome and stick at either end, never wrap.
    function automatic bp_cnt_t bpCntUpdate(input bp_cnt_t cnt, input logic taken);
        bp_cnt_t result;
        result = cnt;
        if (taken && (cnt != STRONG_T)) begin
            result = bp_cnt_t'(cnt + 2'd1);
        end else if (!taken && (cnt != STRONG_NT)) begin
            result = bp_cnt_t'(cnt - 2'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between fetch/decode/hazard control and the branch predictor.
// Signals:
//   pc_f, instr_f               fetch PC and fetched instruction
//   stall_if_id, flush_if_id    IF/ID hold and squash from the hazard controller
//   predict_taken_f/target_f    fetch redirect request and target
//   branch_predict              prediction carried with the instruction in ID
//   resolve_valid/taken/target  branch outcome from ID
//   mispredict                  resolved outcome disagrees with the prediction
// Modports: master drives fetch/resolve, slave is the predictor.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic [XLEN-1:0] pc_f;
    instr_t          instr_f;
    logic            stall_if_id;
    logic            flush_if_id;
    logic            predict_taken_f;
    logic [XLEN-1:0] predict_target_f;
    logic            branch_predict;
    logic            resolve_valid;
    logic            resolve_taken;
    logic [XLEN-1:0] resolve_target;
    logic            mispredict;

    modport master (
        output pc_f, instr_f, stall_if_id, flush_if_id,
               resolve_valid, resolve_taken, resolve_target,
        input  predict_taken_f, predict_target_f, branch_predict, mispredict
    );

    modport slave (
        input  pc_f, instr_f, stall_if_id, flush_if_id,
               resolve_valid, resolve_taken, resolve_target,
        output predict_taken_f, predict_target_f, branch_predict, mispredict
    );

endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer.
// Ports:
//   clk, rst_n         clock, async active-low reset (clears valid bits only)
//   rd_pc_i            lookup PC (combinational read port)
//   rd_hit_o           entry valid and tag matches
//   rd_target_o        stored target of the indexed entry
//   wr_en_i            write strobe, applied at posedge
//   wr_pc_i            PC selecting the entry and tag to write
//   wr_target_i        target to store
module branch_target_buffer
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic            rd_hit_o,
    output logic [XLEN-1:0] rd_target_o,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic [XLEN-1:0] wr_target_i
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [XLEN-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [IDX_BITS-1:0] rdIdx;
    logic [IDX_BITS-1:0] wrIdx;
    logic [XLEN-1:0]     rdTag;
    logic [XLEN-1:0]     wrTag;
    btb_entry_t          rdEntry;

    assign rdIdx = rd_pc_i[IDX_BITS+1:2];
    assign wrIdx = wr_pc_i[IDX_BITS+1:2];
    assign rdTag = rd_pc_i >> (IDX_BITS + 2);
    assign wrTag = wr_pc_i >> (IDX_BITS + 2);

    assign rdEntry     = '{valid: valid_q[rdIdx], tag: tag_q[rdIdx], target: target_q[rdIdx]};
    assign rd_hit_o    = rdEntry.valid && (rdEntry.tag == rdTag);
    assign rd_target_o = rdEntry.target;

    // Valid bits are the only BTB state that reset must clear; a write always
    // sets the bit, so entries are overwritten but never invalidated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wrIdx] <= 1'b1;
        end
    end

    // Tag and target need no reset because they are ignored while invalid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wrIdx]    <= wrTag;
            target_q[wrIdx] <= wr_target_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage gshare branch predictor.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   bp (slave)    fetch lookup, IF/ID control, prediction into ID and
//                 resolution/training; see branch_predictor_if
// Holds the pattern table of 2-bit counters, the global history register and
// the F->D register carrying {prediction, table index, PC} into decode.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS,
    parameter int GHR_BITS = BP_GHR_BITS
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bp
);

    localparam int ENTRIES = 1 << IDX_BITS;

    bp_cnt_t             pht_q [ENTRIES];
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;

    logic                fdPred_q;
    logic                fdPred_d;
    logic [IDX_BITS-1:0] fdIdx_q;
    logic [IDX_BITS-1:0] fdIdx_d;
    logic [XLEN-1:0]     fdPc_q;
    logic [XLEN-1:0]     fdPc_d;

    logic [IDX_BITS-1:0] idxF;
    logic [1:0]          cntF;
    logic                isBranch;
    logic                btbHit;
    logic [XLEN-1:0]     btbTarget;
    logic                predTaken;
    logic                updateEn;
    logic                unusedBits;

    assign unusedBits = ^{bp.instr_f.funct7, bp.instr_f.rs2, bp.instr_f.rs1,
                          bp.instr_f.funct3, bp.instr_f.rd};

    // History is zero-extended into the index before the XOR.
    assign idxF      = bp.pc_f[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign cntF      = pht_q[idxF];
    assign isBranch  = (bp.instr_f.opcode == OPCODE_BRANCH);
    assign predTaken = isBranch && btbHit && cntF[1];

    // A resolution presented during a stall is dropped; hazard control
    // presents it again once the stall releases.
    assign updateEn  = bp.resolve_valid && !bp.stall_if_id;
    assign ghr_d     = {ghr_q[GHR_BITS-2:0], bp.resolve_taken};

    assign bp.predict_taken_f  = predTaken;
    assign bp.predict_target_f = predTaken ? btbTarget : '0;
    assign bp.branch_predict   = fdPred_q;
    assign bp.mispredict       = updateEn && (fdPred_q != bp.resolve_taken);

    branch_target_buffer #(
        .IDX_BITS (IDX_BITS)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_pc_i     (bp.pc_f),
        .rd_hit_o    (btbHit),
        .rd_target_o (btbTarget),
        .wr_en_i     (updateEn && bp.resolve_taken),
        .wr_pc_i     (fdPc_q),
        .wr_target_i (bp.resolve_target)
    );

    // F->D next state: flush wins over stall, stall holds, otherwise capture
    // the fetch-stage prediction and the index it was made with.
    always_comb begin
        fdPred_d = fdPred_q;
        fdIdx_d  = fdIdx_q;
        fdPc_d   = fdPc_q;
        if (bp.flush_if_id) begin
            fdPred_d = 1'b0;
            fdIdx_d  = '0;
            fdPc_d   = '0;
        end else if (!bp.stall_if_id) begin
            fdPred_d = predTaken;
            fdIdx_d  = idxF;
            fdPc_d   = bp.pc_f;
        end
    end

    // F->D register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fdPred_q <= 1'b0;
            fdIdx_q  <= '0;
            fdPc_q   <= '0;
        end else begin
            fdPred_q <= fdPred_d;
            fdIdx_q  <= fdIdx_d;
            fdPc_q   <= fdPc_d;
        end
    end

    // Training uses the index captured at fetch, not the current history, so
    // the counter that made the prediction is the one that learns. There is
    // no bypass: a same-cycle lookup sees the counter before this write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= WEAK_NT;
            end
        end else if (updateEn) begin
            pht_q[fdIdx_q] <= bpCntUpdate(pht_q[fdIdx_q], bp.resolve_taken);
        end
    end

    // History is non-speculative: it shifts only on resolution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (updateEn) begin
            ghr_q <= ghr_d;
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor feeding the hazard controller. Per fetched branch it produces a taken prediction and target for the PC mux. It carries that prediction into decode as `branch_predict`, where the hazard controller compares it against the resolved outcome. On resolution it trains a gshare pattern table of 2-bit counters and a direct-mapped branch target buffer (BTB).

## Interface
Parameters:
- `IDX_BITS`, 6: pattern-table/BTB index width (64 entries).
- `GHR_BITS`, 6: global history length, ≤ `IDX_BITS`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc_f`  in  XLEN  fetch PC.
- `instr_f`  in  instr_t  fetched instruction.
- `stall_if_id`  in  1  hold IF/ID; from hazard controller.
- `flush_if_id`  in  1  squash IF/ID; from hazard controller.
- `predict_taken_f`  out  1  redirect fetch this cycle.
- `predict_target_f`  out  XLEN  redirect target; 0 when not taken.
- `branch_predict`  out  1  registered prediction for the instruction in ID.
- `resolve_valid`  in  1  ID branch resolved this cycle.
- `resolve_taken`  in  1  actual outcome; same signal as `branch_actual`.
- `resolve_target`  in  XLEN  actual taken target.
- `mispredict`  out  1  `resolve_valid & !stall_if_id & (branch_predict != resolve_taken)`.

## Operation
- Index: `idx_f = pc_f[IDX_BITS+1:2] ^ {'0, ghr}`.
- BTB index: `pc_f[IDX_BITS+1:2]`.
- BTB tag: `pc_f[XLEN-1:IDX_BITS+2]`.
- BTB hit: entry valid and tag matches.
- Prediction: `predict_taken_f = (instr_f.opcode == B) & btb_hit & pht[idx_f][1]`. Non-branches always predict not-taken.
- `predict_target_f = btb_target` when `predict_taken_f`, else 0.
- Counter encoding is `bp_cnt_t`: STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3.
- Counter update saturates: taken increments (max 3), not-taken decrements (min 0).
- F→D register holds `{pred, idx, pc}`:
  - flush: loads `{0, 0, 0}`.
  - else stall: holds.
  - else: captures F values.
  - Flush has priority over stall.
- An update fires when `resolve_valid & !stall_if_id`. It uses the registered `idx_d`/`pc_d`, never the current GHR. Each update performs:
  - PHT: saturating update of `pht[idx_d]`.
  - GHR: `ghr <= {ghr[GHR_BITS-2:0], resolve_taken}`.
  - BTB: only if `resolve_taken`, write entry `pc_d` as `{valid=1, tag, resolve_target}`, overwriting. Not-taken never invalidates.
- `resolve_valid` while stalled is ignored: no update, `mispredict`=0. The branch is re-presented once the stall drops.
- Non-speculative history: the GHR changes only on resolution.

## Timing
- Reset values:
  - every PHT entry WEAK_NT; all BTB valid bits 0; GHR 0.
  - F→D register 0, so `branch_predict`=0.
  - `predict_taken_f`=0, `predict_target_f`=0, `mispredict`=0.
- Reset asserted mid-operation clears all state immediately; a pending update is lost.
- F outputs are combinational from `pc_f`/`instr_f` in the same cycle. `branch_predict` is valid the cycle after capture.
- An update writes at the posedge; its effect is visible to lookups from the next cycle.
- A same-cycle lookup and update of the same entry returns the pre-update value; there is no bypass.
- Back-to-back resolutions on consecutive cycles must each apply, in order.
- Wrap-around: counters saturate and never wrap. Index bits alias freely; aliasing is accepted.

## Structure
- Add to `defines`: `bp_cnt_t` enum, `BP_IDX_BITS`/`BP_GHR_BITS` defaults, and a `btb_entry_t` struct `{valid, tag, target}`.
- Sub-module `branch_target_buffer`:
  - direct-mapped storage with async-clear valid bits.
  - one combinational read port.
  - one synchronous write port.
- The PHT, GHR and F→D register stay in `branch_predictor`.

## Test plan
- **Reset:** deassert `rst_n`, fetch a branch at `pc_f`=0x100. Expect `predict_taken_f`=0, and `branch_predict`=0 next cycle.
- **Training:** resolve the branch at 0x100 taken to 0x80, twice, holding `ghr`=0 by preloading history.
  - Expect: next fetch at 0x100 gives `predict_taken_f`=1, `predict_target_f`=0x80.
  - Expect: 4 not-taken resolutions then give `predict_taken_f`=0. Counter 3→0, no underflow.
- **Stall/flush:**
  - Predict taken, then assert `stall_if_id` 3 cycles: `branch_predict` stays 1 and `resolve_valid` is ignored (`mispredict`=0).
  - `flush_if_id` with stall: `branch_predict`=0 next cycle.
- **Mispredict:** `branch_predict`=1, `resolve_taken`=0 → `mispredict`=1 same cycle; GHR LSB=0 next cycle.
- **Collision:** update and lookup of the same index in the same cycle → the lookup returns the old counter, and the new value is seen next cycle.
- **Async reset mid-update:** pulse `rst_n` low between edges → all outputs 0 immediately, and the BTB misses afterward.
